// File: rtl/mb_train_pkg.sv
// Shared definitions for mainband training blocks: mode encodings,
// FSM state encodings and a legal-mode helper.
package mb_train_pkg;

    localparam logic [1:0] MODE_ITER   = 2'b01;
    localparam logic [1:0] MODE_CONSEC = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_ITER) || (mode == MODE_CONSEC);
    endfunction

endpackage

// File: rtl/mb_valtrain_seg_cmp.sv
// Combinational per-beat compare of NSEG pattern segments against PATTERN.
// Segment k = data[k*PAT_W +: PAT_W]; segment NSEG-1 is the oldest.
module mb_valtrain_seg_cmp #(
    parameter int unsigned            PAT_W   = 8,
    parameter logic [PAT_W-1:0]       PATTERN = 8'hF0,
    parameter int unsigned            NSEG    = 4,
    parameter int unsigned            MW      = $clog2(NSEG*PAT_W+1),
    parameter int unsigned            LW      = $clog2(NSEG+1)
) (
    input  logic [NSEG*PAT_W-1:0] data,
    output logic [NSEG-1:0]       seg_ok,
    output logic [MW-1:0]         mismatch,
    output logic [LW-1:0]         lead,
    output logic [LW-1:0]         trail
);

    // Per-segment equality, total bit-error popcount and the matching run
    // lengths at the old (lead) and new (trail) ends of the beat.
    always_comb begin
        logic [PAT_W-1:0] diff;
        logic             lead_on;
        logic             trail_on;
        seg_ok   = '0;
        mismatch = '0;
        lead     = '0;
        trail    = '0;
        diff     = '0;
        lead_on  = 1'b1;
        trail_on = 1'b1;
        for (int unsigned k = 0; k < NSEG; k++) begin
            diff      = data[k*PAT_W +: PAT_W] ^ PATTERN;
            seg_ok[k] = (diff == '0);
            for (int unsigned b = 0; b < PAT_W; b++) begin
                mismatch = mismatch + MW'(diff[b]);
            end
        end
        for (int unsigned i = 0; i < NSEG; i++) begin
            lead_on  = lead_on & seg_ok[NSEG-1-i];
            lead     = lead + LW'(lead_on);
            trail_on = trail_on & seg_ok[i];
            trail    = trail + LW'(trail_on);
        end
    end

endmodule

// File: rtl/mb_valtrain_detector.sv
// Mainband RX valid-lane VALTRAIN checker. One measurement per accepted
// start, in ITER (error total vs threshold) or CONSEC (consecutive matching
// segments) mode. Result reported as a done pulse plus a held pass flag.
module mb_valtrain_detector
    import mb_train_pkg::*;
#(
    parameter int unsigned      PAT_W         = 8,
    parameter logic [PAT_W-1:0] PATTERN       = 8'hF0,
    parameter int unsigned      NSEG          = 4,
    parameter int unsigned      CNT_W         = 12,
    parameter int unsigned      CONSEC_TARGET = 16,
    parameter int unsigned      ITER_MAX      = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [NSEG*PAT_W-1:0] i_data,
    input  logic                  i_data_vld,
    input  logic [CNT_W-1:0]      i_err_thresh,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [CNT_W-1:0]      o_err_cnt,
    output logic [7:0]            o_run_len
);

    localparam int unsigned MW = $clog2(NSEG*PAT_W+1);
    localparam int unsigned LW = $clog2(NSEG+1);
    localparam int unsigned BW = $clog2(ITER_MAX+1);
    localparam int unsigned EW = CNT_W + 1;

    state_e           state;
    logic [1:0]       mode_q;
    logic [BW-1:0]    beat_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       run_len;
    logic             pass_q;

    logic [NSEG-1:0]  seg_ok;
    logic [MW-1:0]    mismatch;
    logic [LW-1:0]    lead;
    logic [LW-1:0]    trail;

    logic [BW-1:0]    beat_nxt;
    logic             last_beat;
    logic [EW-1:0]    err_sum;
    logic [CNT_W-1:0] err_new;
    logic [8:0]       run_all;
    logic [7:0]       run_new;
    logic             consec_hit;

    mb_valtrain_seg_cmp #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .NSEG    (NSEG),
        .MW      (MW),
        .LW      (LW)
    ) u_seg_cmp (
        .data     (i_data),
        .seg_ok   (seg_ok),
        .mismatch (mismatch),
        .lead     (lead),
        .trail    (trail)
    );

    // Next-value arithmetic for the counters: saturating error sum,
    // saturating run length, and the mid-beat CONSEC target check.
    always_comb begin
        beat_nxt   = beat_cnt + BW'(1);
        last_beat  = (beat_nxt == BW'(ITER_MAX));
        err_sum    = {1'b0, err_cnt} + EW'(mismatch);
        err_new    = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        run_all    = {1'b0, run_len} + 9'(NSEG);
        run_new    = (&seg_ok) ? (run_all[8] ? '1 : run_all[7:0]) : 8'(trail);
        consec_hit = ({1'b0, run_len} + 9'(lead)) >= 9'(CONSEC_TARGET);
    end

    // Measurement FSM with beat counter, accumulators and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            mode_q   <= MODE_ITER;
            beat_cnt <= '0;
            err_cnt  <= '0;
            run_len  <= '0;
            pass_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start && mode_legal(i_mode)) begin
                        state    <= RUN;
                        mode_q   <= i_mode;
                        beat_cnt <= '0;
                        err_cnt  <= '0;
                        run_len  <= '0;
                        pass_q   <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (i_data_vld) begin
                        beat_cnt <= beat_nxt;
                        if (mode_q == MODE_ITER) begin
                            err_cnt <= err_new;
                            if (last_beat) begin
                                state  <= DONE;
                                pass_q <= (err_new <= i_err_thresh);
                            end
                        end else if (consec_hit) begin
                            state  <= DONE;
                            pass_q <= 1'b1;
                        end else begin
                            run_len <= run_new;
                            if (last_beat) begin
                                state  <= DONE;
                                pass_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy    = (state == RUN);
    assign o_done    = (state == DONE);
    assign o_pass    = pass_q;
    assign o_err_cnt = err_cnt;
    assign o_run_len = run_len;

endmodule

// File: tb/tb_mb_valtrain_detector.sv
// Randomized self-checking bench for mb_valtrain_detector against a
// segment-stream reference model.
module tb_mb_valtrain_detector;
    import mb_train_pkg::*;

    localparam int unsigned   PAT_W    = 8;
    localparam int unsigned   NSEG     = 4;
    localparam int unsigned   CNT_W    = 12;
    localparam int unsigned   TARGET   = 16;
    localparam int unsigned   ITER_MAX = 128;
    localparam logic [7:0]    PAT      = 8'hF0;
    localparam int            ERR_MAX  = 4095;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_start;
    logic [1:0]        i_mode;
    logic [31:0]       i_data;
    logic              i_data_vld;
    logic [CNT_W-1:0]  i_err_thresh;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic [CNT_W-1:0]  o_err_cnt;
    logic [7:0]        o_run_len;

    mb_valtrain_detector #(
        .PAT_W         (PAT_W),
        .PATTERN       (PAT),
        .NSEG          (NSEG),
        .CNT_W         (CNT_W),
        .CONSEC_TARGET (TARGET),
        .ITER_MAX      (ITER_MAX)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_data       (i_data),
        .i_data_vld   (i_data_vld),
        .i_err_thresh (i_err_thresh),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_err_cnt    (o_err_cnt),
        .o_run_len    (o_run_len)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: error total, valid beats, matching-segment streak.
    int m_err;
    int m_vcnt;
    int m_streak;
    bit m_done;
    bit m_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bit_errs(input logic [31:0] d);
        logic [31:0] x;
        int n;
        x = d ^ {NSEG{PAT}};
        n = 0;
        for (int b = 0; b < 32; b++) n += int'(x[b]);
        return n;
    endfunction

    // ITER: plain saturating sum. CONSEC: walk segments oldest-first as one
    // continuous stream; pass as soon as the streak reaches TARGET.
    task automatic model_beat(input logic [1:0] mode, input logic [31:0] d, input int thresh);
        logic [7:0] seg;
        bit hit;
        if (mode == MODE_ITER) begin
            m_err = m_err + bit_errs(d);
            if (m_err > ERR_MAX) m_err = ERR_MAX;
            m_vcnt++;
            if (m_vcnt == ITER_MAX) begin
                m_done = 1'b1;
                m_pass = (m_err <= thresh);
            end
        end else begin
            hit = 1'b0;
            for (int s = NSEG - 1; s >= 0; s--) begin
                if (!hit) begin
                    seg = d[s*8 +: 8];
                    if (seg == PAT) begin
                        m_streak++;
                        if (m_streak >= TARGET) hit = 1'b1;
                    end else begin
                        m_streak = 0;
                    end
                end
            end
            m_vcnt++;
            if (hit) begin
                m_done = 1'b1;
                m_pass = 1'b1;
            end else if (m_vcnt == ITER_MAX) begin
                m_done = 1'b1;
                m_pass = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] gen(input int kind, input int idx);
        logic [31:0] d;
        d = '0;
        case (kind)
            0: d = 32'hF0F0F0F0;
            1: d = 32'hF0F0F0F1;
            2: d = 32'h0F0F0F0F;
            3: begin
                if (idx == 0)     d = 32'h00F0F0F0;
                else if (idx < 4) d = 32'hF0F0F0F0;
                else if (idx == 4) d = 32'hF0000000;
                else              d = $urandom;
            end
            4: d = (idx % 2 == 0) ? 32'hF0F0F000 : 32'h00F0F0F0;
            default: begin
                for (int k = 0; k < NSEG; k++) begin
                    if ($urandom_range(0, 3) != 0) d[k*8 +: 8] = PAT;
                    else                           d[k*8 +: 8] = 8'($urandom);
                end
            end
        endcase
        return d;
    endfunction

    // One measurement: start (from IDLE or DONE), feed beats, check per cycle.
    task automatic run_case(input logic [1:0] mode, input int thresh, input int kind,
                            input int gap_pct, input bit chain, input int abort_at,
                            input bit poke);
        int vidx;
        int cyc;
        logic [31:0] d;
        bit v;
        i_start      = 1'b1;
        i_mode       = mode;
        i_err_thresh = CNT_W'(thresh);
        i_data_vld   = 1'b0;
        @(negedge i_clk);
        i_start  = 1'b0;
        m_err    = 0;
        m_vcnt   = 0;
        m_streak = 0;
        m_done   = 1'b0;
        m_pass   = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("pass_cleared", 32'(o_pass), 32'd0);
        chk("err_cleared", 32'(o_err_cnt), 32'd0);
        vidx = 0;
        cyc  = 0;
        while (!m_done && cyc < 2000) begin
            if (abort_at != 0 && vidx == abort_at) break;
            d = gen(kind, vidx);
            v = ($urandom_range(0, 99) >= gap_pct);
            i_data     = d;
            i_data_vld = v;
            if (poke && vidx == 10) begin
                i_start = 1'b1;
                i_mode  = (mode == MODE_ITER) ? MODE_CONSEC : MODE_ITER;
            end
            @(negedge i_clk);
            i_start = 1'b0;
            cyc++;
            if (v) begin
                model_beat(mode, d, thresh);
                vidx++;
            end
            chk("done", 32'(o_done), 32'(m_done));
            chk("busy", 32'(o_busy), 32'(!m_done));
            chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
            if (m_done) begin
                chk("pass", 32'(o_pass), 32'(m_pass));
            end else if (mode == MODE_CONSEC) begin
                chk("run_len", 32'(o_run_len), 32'((m_streak > 255) ? 255 : m_streak));
            end
        end
        i_data_vld = 1'b0;
        if (abort_at == 0) begin
            chk("finished_in_budget", 32'(m_done), 32'd1);
            if (!chain) begin
                @(negedge i_clk);
                chk("done_one_cycle", 32'(o_done), 32'd0);
                chk("idle_not_busy", 32'(o_busy), 32'd0);
                chk("pass_held", 32'(o_pass), 32'(m_pass));
                chk("err_held", 32'(o_err_cnt), 32'(m_err));
            end
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_mode       = 2'b00;
        i_data       = '0;
        i_data_vld   = 1'b0;
        i_err_thresh = '0;
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_pass", 32'(o_pass), 32'd0);
        chk("rst_err", 32'(o_err_cnt), 32'd0);
        chk("rst_run", 32'(o_run_len), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Illegal modes leave the block idle.
        for (int m = 0; m < 4; m += 3) begin
            i_start = 1'b1;
            i_mode  = 2'(m);
            @(negedge i_clk);
            i_start = 1'b0;
            chk("illegal_mode_ignored", 32'(o_busy), 32'd0);
            @(negedge i_clk);
        end

        run_case(MODE_ITER,   0,    0, 0,  1'b0, 0, 1'b0);
        run_case(MODE_ITER,   127,  1, 0,  1'b1, 0, 1'b0);
        run_case(MODE_ITER,   128,  1, 0,  1'b0, 0, 1'b1);
        run_case(MODE_ITER,   4094, 2, 20, 1'b0, 0, 1'b0);
        run_case(MODE_CONSEC, 0,    3, 0,  1'b1, 0, 1'b0);
        run_case(MODE_CONSEC, 0,    4, 30, 1'b0, 0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            run_case(MODE_CONSEC, 0, 5, 25, r[0], 0, 1'b0);
            run_case(MODE_ITER, int'($urandom_range(300, 700)), 5, 25, 1'b0, 0, 1'b0);
        end

        // Reset in the middle of a run, then a fresh full-length run.
        run_case(MODE_ITER, 0, 0, 10, 1'b0, 50, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_err", 32'(o_err_cnt), 32'd0);
        repeat (2) begin
            @(negedge i_clk);
            chk("midrst_no_done", 32'(o_done), 32'd0);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("after_rst_idle", 32'(o_busy), 32'd0);
        chk("after_rst_no_done", 32'(o_done), 32'd0);
        run_case(MODE_ITER, 0, 0, 15, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
